// File: rtl/uart_packet_assembler_if.sv
// Byte-in / frame-out bus for uart_packet_assembler.
// slave is the assembler's view; master is the surrounding receiver/FIFO side.
interface uart_packet_assembler_if #(
    parameter int PACKET_BYTES = 6
);
    logic                      rx_dv;
    logic [7:0]                uart_byte;
    logic                      hold;
    logic                      full;
    logic [8*PACKET_BYTES-1:0] data_frame;
    logic                      wr_en;

    modport master (output rx_dv, uart_byte, full, input hold, data_frame, wr_en);
    modport slave  (input rx_dv, uart_byte, full, output hold, data_frame, wr_en);
endinterface

// File: rtl/uart_packet_assembler.sv
// Packs PACKET_BYTES received UART bytes into one frame and writes it to a FIFO.
// Define PACKETIZER_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES idle clocks.
module uart_packet_assembler #(
    parameter int          PACKET_BYTES   = 6,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_packet_assembler_if.slave  bus,
    output logic [4:0]              byte_cnt,
    output logic                    overflow,
    output logic                    timeout_err
);
    localparam int unsigned W = 8 * PACKET_BYTES;

    if (PACKET_BYTES < 1 || PACKET_BYTES > 16) begin : g_bad_bytes
        $error("PACKET_BYTES out of range 1..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   asm_q, asm_nx;
    logic [W-1:0]   frame_q, frame_nx;
    logic [4:0]     cnt_nx;
    logic           wr_en_q, wr_en_nx;
    logic           hold_q, hold_nx;
    logic           ovf_nx;

`ifdef PACKETIZER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0]  idle_q, idle_nx;
    logic           to_nx;
`endif

    always_comb begin
        state_nx = state;
        asm_nx   = asm_q;
        frame_nx = frame_q;
        cnt_nx   = byte_cnt;
        wr_en_nx = 1'b0;
        ovf_nx   = 1'b0;
`ifdef PACKETIZER_TIMEOUT_EN
        idle_nx  = '0;
        to_nx    = 1'b0;
`endif
        case (state)
            IDLE, COLLECT: begin
                if (bus.rx_dv) begin
                    // byte_cnt is 0 in IDLE, so both states place the byte at slot byte_cnt
                    for (int unsigned i = 0; i < PACKET_BYTES; i++) begin
                        if (i == 32'(byte_cnt))
                            asm_nx[(MSB_FIRST ? W - 8 - 8*i : 8*i) +: 8] = bus.uart_byte;
                    end
                    cnt_nx   = byte_cnt + 5'd1;
                    state_nx = (cnt_nx == 5'(PACKET_BYTES)) ? EMIT : COLLECT;
                end
`ifdef PACKETIZER_TIMEOUT_EN
                else if (state == COLLECT) begin
                    if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_nx = IDLE;
                        asm_nx   = '0;
                        cnt_nx   = '0;
                        to_nx    = 1'b1;
                    end else begin
                        idle_nx = idle_q + 1'b1;
                    end
                end
`endif
            end
            EMIT: begin
                ovf_nx = bus.rx_dv;
                if (!bus.full) begin
                    frame_nx = asm_q;
                    wr_en_nx = 1'b1;
                    asm_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        hold_nx = (state_nx != EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            asm_q    <= '0;
            frame_q  <= '0;
            byte_cnt <= '0;
            wr_en_q  <= 1'b0;
            hold_q   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            asm_q    <= asm_nx;
            frame_q  <= frame_nx;
            byte_cnt <= cnt_nx;
            wr_en_q  <= wr_en_nx;
            hold_q   <= hold_nx;
            overflow <= ovf_nx;
        end
    end

`ifdef PACKETIZER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            idle_q      <= idle_nx;
            timeout_err <= to_nx;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign bus.data_frame = frame_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.hold       = hold_q;
endmodule
